// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues word fetches under a credit limit, queues
// returned words with their PCs for decode, and flushes/drains on redirect.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  dec_op,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers when imem_req_valid & imem_req_ready, a
  // decode transfer when dec_valid & dec_ready; valid never waits on ready.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FETCH = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] q_wr_q, q_wr_d;
  logic [PW-1:0] q_rd_q, q_rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d;

  logic [31:0] q_instr_mem [DEPTH];
  logic [31:0] q_pc_mem    [DEPTH];
  logic [31:0] tag_mem     [DEPTH];

  logic        in_fetch;
  logic        in_drain;
  logic        q_empty;
  logic        q_full;
  logic        accept;
  logic        rsp_live;
  logic        rsp_push;
  logic        pop;
  logic [CW:0] credit_sum;
  logic [31:0] redirect_aligned;
  logic        unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_fetch         = (state_q == ST_FETCH);
  assign in_drain         = (state_q == ST_DRAIN);
  assign q_empty          = (count_q == '0);
  assign q_full           = (count_q == DEPTH_C);
  assign credit_sum       = {1'b0, count_q} + {1'b0, out_q};
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign unused_bits      = ^redirect_pc[1:0];

  // Queued words plus words in flight never exceed DEPTH, so a response
  // always finds a free slot.
  assign imem_req_valid = in_fetch & ~redirect_valid & (credit_sum < {1'b0, DEPTH_C});
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  assign dec_valid = in_fetch & ~q_empty & ~redirect_valid;
  assign pop       = dec_valid & dec_ready;
  assign dec_instr = q_empty ? '0 : q_instr_mem[q_rd_q];
  assign dec_pc    = q_empty ? '0 : q_pc_mem[q_rd_q];
  assign dec_op    = dec_valid ? dec_instr[6:0] : 7'b0000000;
  assign dbg_state = state_q;

  // A response with nothing outstanding cannot be matched to a tag; ignore it.
  assign rsp_live = imem_rsp_valid & (in_fetch | in_drain) & (out_q != '0);
  assign rsp_push = rsp_live & in_fetch & ~redirect_valid & (~q_full | pop);

  always_comb begin
    out_d = out_q;
    case ({accept, rsp_live})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    q_wr_d   = q_wr_q;
    q_rd_d   = q_rd_q;
    count_d  = count_q;
    disc_d   = disc_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_d     = redirect_aligned;
          q_wr_d   = '0;
          q_rd_d   = '0;
          count_d  = '0;
          tag_wr_d = '0;
          tag_rd_d = '0;
          disc_d   = out_d;
          state_d  = (out_d == '0) ? ST_FETCH : ST_DRAIN;
        end else begin
          if (accept) begin
            pc_d     = pc_q + 32'd4;
            tag_wr_d = ptr_inc(tag_wr_q);
          end
          if (rsp_live) tag_rd_d = ptr_inc(tag_rd_q);
          if (rsp_push) q_wr_d = ptr_inc(q_wr_q);
          if (pop)      q_rd_d = ptr_inc(q_rd_q);
          case ({rsp_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
      end
      ST_DRAIN: begin
        // Every response here belongs to a flushed stream.
        if (rsp_live && (disc_q != '0)) disc_d = disc_q - 1'b1;
        if (redirect_valid) begin
          pc_d     = redirect_aligned;
          q_wr_d   = '0;
          q_rd_d   = '0;
          count_d  = '0;
          tag_wr_d = '0;
          tag_rd_d = '0;
        end
        if (disc_d == '0) state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      q_wr_q   <= '0;
      q_rd_q   <= '0;
      count_q  <= '0;
      out_q    <= '0;
      disc_q   <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      q_wr_q   <= q_wr_d;
      q_rd_q   <= q_rd_d;
      count_q  <= count_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
    end
  end

  // Storage needs no reset: every read is gated by occupancy or outstanding count.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr_q] <= pc_q;
    if (rsp_push) begin
      q_instr_mem[q_wr_q] <= imem_rsp_data;
      q_pc_mem[q_wr_q]    <= tag_mem[tag_rd_q];
    end
  end

endmodule
